// File: rtl/ikaopm_dac_rx_if.sv
// Serial DAC link (SO/SH1/SH2 with bit enable) plus the parallel PCM result.
// o_FRAMEERR exists only when IKAOPM_DAC_FRAMECHK_EN is defined.
interface ikaopm_dac_rx_if;
    logic        i_CEN_n;
    logic        i_SO;
    logic        i_SH1;
    logic        i_SH2;
    logic [15:0] o_L;
    logic [15:0] o_R;
    logic        o_L_VALID;
    logic        o_R_VALID;
`ifdef IKAOPM_DAC_FRAMECHK_EN
    logic        o_FRAMEERR;

    modport master (output i_CEN_n, i_SO, i_SH1, i_SH2,
                    input  o_L, o_R, o_L_VALID, o_R_VALID, o_FRAMEERR);
    modport slave  (input  i_CEN_n, i_SO, i_SH1, i_SH2,
                    output o_L, o_R, o_L_VALID, o_R_VALID, o_FRAMEERR);
`else
    modport master (output i_CEN_n, i_SO, i_SH1, i_SH2,
                    input  o_L, o_R, o_L_VALID, o_R_VALID);
    modport slave  (input  i_CEN_n, i_SO, i_SH1, i_SH2,
                    output o_L, o_R, o_L_VALID, o_R_VALID);
`endif
endinterface

// File: rtl/ikaopm_dac_rx.sv
// OPM serial DAC receiver: 13-bit float words -> 16-bit signed PCM per channel; optional frame checker (IKAOPM_DAC_FRAMECHK_EN).
// Latency: latch at edge E, sample and VALID pulse registered at E+1.
// Backpressure: none; accepts one sample per channel per bit enable.
module ikaopm_dac_rx #(
    parameter int FRAME_BITS = 16
) (
    input  logic            i_EMUCLK,
    input  logic            i_RST_n,
    ikaopm_dac_rx_if.slave  dac
);
    // The bit counter is 6 bits wide and saturates at 63.
    if (FRAME_BITS < 1 || FRAME_BITS > 63) begin : g_frame_bits_range
        $error("FRAME_BITS must be within 1..63");
    end

    logic [15:0] sr_q, sr_d;
    logic        sh1_q, sh1_d, sh2_q, sh2_d;
    logic [15:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic        lat_l_q, lat_l_d, lat_r_q, lat_r_d;
    logic [15:0] l_q, l_d, r_q, r_d;
    logic        l_vld_q, l_vld_d, r_vld_q, r_vld_d;
    logic        en, fall1, fall2;

    // Offset-binary mantissa becomes signed by flipping its MSB; exponent 0 means silence.
    function automatic logic [15:0] lin(input logic [15:0] w);
        logic signed [15:0] s;
        s = {{6{~w[12]}}, ~w[12], w[11:3]};
        if (w[15:13] == 3'd0) lin = 16'd0;
        else                  lin = s <<< (w[15:13] - 3'd1);
    endfunction

    assign en    = ~dac.i_CEN_n;
    assign fall1 = en & sh1_q & ~dac.i_SH1;
    assign fall2 = en & sh2_q & ~dac.i_SH2;

    always_comb begin
        sr_d    = sr_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        cap_l_d = cap_l_q;
        cap_r_d = cap_r_q;
        if (en) begin
            sr_d  = {dac.i_SO, sr_q[15:1]};
            sh1_d = dac.i_SH1;
            sh2_d = dac.i_SH2;
        end
        // Capture the word as it stood before this enable's shift.
        if (fall1) cap_l_d = sr_q;
        if (fall2) cap_r_d = sr_q;
        lat_l_d = fall1;
        lat_r_d = fall2;
        l_d     = lat_l_q ? lin(cap_l_q) : l_q;
        r_d     = lat_r_q ? lin(cap_r_q) : r_q;
        l_vld_d = lat_l_q;
        r_vld_d = lat_r_q;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            sr_q    <= '0;
            sh1_q   <= 1'b0;
            sh2_q   <= 1'b0;
            cap_l_q <= '0;
            cap_r_q <= '0;
            lat_l_q <= 1'b0;
            lat_r_q <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            l_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            cap_l_q <= cap_l_d;
            cap_r_q <= cap_r_d;
            lat_l_q <= lat_l_d;
            lat_r_q <= lat_r_d;
            l_q     <= l_d;
            r_q     <= r_d;
            l_vld_q <= l_vld_d;
            r_vld_q <= r_vld_d;
        end
    end

    assign dac.o_L       = l_q;
    assign dac.o_R       = r_q;
    assign dac.o_L_VALID = l_vld_q;
    assign dac.o_R_VALID = r_vld_q;

`ifdef IKAOPM_DAC_FRAMECHK_EN
    logic [5:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    logic       err_q, err_d;

    // The first latch after reset only arms the checker, so a partial frame is tolerated.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        err_d   = err_q;
        if (en) begin
            if (fall1 || fall2) begin
                if (armed_q && (cnt_q != 6'(FRAME_BITS))) err_d = 1'b1;
                cnt_d   = 6'd1;
                armed_d = 1'b1;
            end else if (cnt_q != 6'd63) begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    assign dac.o_FRAMEERR = err_q;
`endif
endmodule
